bcd_tone_generator: RTL and testbench

- Transmit-side counterpart of the mic signal handler: takes a 4-digit BCD frequency (thousands/hundreds/tens/ones) and drives a square wave of that frequency on a Pmod pin for one measurement window.
- Used as a self-test source for the mic path: loop tone_out back into the handler and read the same digits on the display.
- Sequential BCD-to-binary conversion, then a bit-serial divider for the half-period, then a timed play phase; all driven by a start/busy/done handshake.

---
 rtl/bcd_tone_generator_pkg.sv | 18 +
 rtl/bcd_tone_generator_serial_divider.sv | 61 ++++++
 rtl/bcd_tone_generator.sv | 168 ++++++++++++++++
 tb/tb_bcd_tone_generator.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_tone_generator_pkg.sv
// Shared definitions for the BCD tone generator: FSM encoding,
// BCD digit limit and the board clock frequency used by the audio blocks.
package bcd_tone_generator_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CHECK   = 3'd1,
        S_CONVERT = 3'd2,
        S_DIVIDE  = 3'd3,
        S_PLAY    = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    localparam int DEFAULT_CLK_HZ = 100_000_000;

endpackage

// File: rtl/bcd_tone_generator_serial_divider.sv
// Bit-serial restoring divider: one quotient bit per clock, W clocks per divide.
// Ports: clk, reset (sync, high), start, dividend, divisor -> busy, done, quotient.
module serial_divider #(
    parameter int W = 27
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient
);

    localparam int SW = $clog2(W + 1);

    logic [SW-1:0] step;
    logic [W-1:0]  rem;
    logic [W-1:0]  q;
    logic [W-1:0]  dvs;
    logic [W:0]    shifted;
    logic [W:0]    trial;

    // The dividend is shifted out of q's MSB while quotient bits enter its LSB.
    assign shifted  = {rem, q[W-1]};
    assign trial    = shifted - {1'b0, dvs};
    // done marks the cycle whose closing edge writes the last quotient bit.
    assign done     = busy && (step == SW'(W - 1));
    assign quotient = q;

    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= 1'b0;
            step <= '0;
            rem  <= '0;
            q    <= '0;
            dvs  <= '0;
        end else if (start) begin
            busy <= 1'b1;
            step <= '0;
            rem  <= '0;
            q    <= dividend;
            dvs  <= divisor;
        end else if (busy) begin
            // A clear borrow bit means the trial subtraction fits.
            if (!trial[W]) begin
                rem <= trial[W-1:0];
                q   <= {q[W-2:0], 1'b1};
            end else begin
                rem <= shifted[W-1:0];
                q   <= {q[W-2:0], 1'b0};
            end
            step <= step + SW'(1);
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/bcd_tone_generator.sv
// Plays a square wave at a 4-digit BCD frequency for one measurement window.
// Ports: clk, reset, start, stop, 4 BCD digits -> tone_out, busy, done, err_bcd.
module bcd_tone_generator
    import bcd_tone_generator_pkg::*;
#(
    parameter int CLK_HZ          = DEFAULT_CLK_HZ,
    parameter int DURATION_CYCLES = 100_000_000,
    parameter int DIV_W           = 27
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic [3:0] Thousands_Data,
    input  logic [3:0] Hundreds_Data,
    input  logic [3:0] Tens_Data,
    input  logic [3:0] Ones_Data,
    output logic       tone_out,
    output logic       busy,
    output logic       done,
    output logic       err_bcd
);

    localparam logic [DIV_W-1:0] DIVIDEND = DIV_W'(CLK_HZ);
    localparam logic [DIV_W-1:0] DUR_LAST = DIV_W'(DURATION_CYCLES - 1);
    localparam logic [31:0]      DIV_MAX  = 32'((64'd1 << DIV_W) - 64'd1);

    state_t           state;
    logic [15:0]      bcd;
    logic [13:0]      acc;
    logic [13:0]      acc_next;
    logic [1:0]       cnt;
    logic [3:0]       digit;
    logic [DIV_W-1:0] phase;
    logic [DIV_W-1:0] dur;
    logic [DIV_W-1:0] half;
    logic             silent;
    logic             bad_digit;

    logic [31:0]      twice;
    logic [DIV_W-1:0] divisor;
    logic             div_start;
    logic             div_busy;
    logic             div_done;
    logic [DIV_W-1:0] div_q;

    always_comb begin
        digit = '0;
        case (cnt)
            2'd0: digit = bcd[15:12];
            2'd1: digit = bcd[11:8];
            2'd2: digit = bcd[7:4];
            2'd3: digit = bcd[3:0];
        endcase
    end

    assign acc_next  = (acc << 3) + (acc << 1) + {10'd0, digit};
    assign bad_digit = (bcd[15:12] > BCD_MAX) || (bcd[11:8] > BCD_MAX) ||
                       (bcd[7:4] > BCD_MAX) || (bcd[3:0] > BCD_MAX);

    // A divisor too wide for the divider saturates, which still yields a
    // zero quotient and therefore the clamped half-period of 1.
    assign twice     = {17'd0, acc_next, 1'b0};
    assign divisor   = (twice > DIV_MAX) ? '1 : twice[DIV_W-1:0];
    assign div_start = (state == S_CONVERT) && (cnt == 2'd3) &&
                       (acc_next != '0);
    assign half      = (div_q == '0) ? DIV_W'(1) : div_q;

    serial_divider #(
        .W(DIV_W)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .dividend (DIVIDEND),
        .divisor  (divisor),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            tone_out <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err_bcd  <= 1'b0;
            bcd      <= '0;
            acc      <= '0;
            cnt      <= '0;
            phase    <= '0;
            dur      <= '0;
            silent   <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    tone_out <= 1'b0;
                    if (start) begin
                        bcd     <= {Thousands_Data, Hundreds_Data,
                                    Tens_Data, Ones_Data};
                        err_bcd <= 1'b0;
                        busy    <= 1'b1;
                        state   <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    acc <= '0;
                    cnt <= '0;
                    if (bad_digit) begin
                        err_bcd <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        state <= S_CONVERT;
                    end
                end
                S_CONVERT: begin
                    acc <= acc_next;
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        phase    <= '0;
                        dur      <= '0;
                        tone_out <= 1'b0;
                        // A zero frequency skips the divider and plays silence.
                        silent   <= (acc_next == '0);
                        state    <= (acc_next == '0) ? S_PLAY : S_DIVIDE;
                    end
                end
                S_DIVIDE: begin
                    // Falling through on an idle divider avoids a stuck FSM.
                    if (div_done || !div_busy) begin
                        state <= S_PLAY;
                    end
                end
                S_PLAY: begin
                    if (stop) begin
                        tone_out <= 1'b0;
                        busy     <= 1'b0;
                        state    <= S_IDLE;
                    end else if (dur == DUR_LAST) begin
                        tone_out <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= S_DONE;
                    end else begin
                        dur <= dur + DIV_W'(1);
                        if (phase == half - DIV_W'(1)) begin
                            phase    <= '0;
                            tone_out <= silent ? 1'b0 : ~tone_out;
                        end else begin
                            phase <= phase + DIV_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_tone_generator.sv
// Directed bench for bcd_tone_generator with a 1 kHz clock and 1000-cycle window.
// Each task drives one scenario and compares against hand-computed values.
module tb_bcd_tone_generator;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       stop;
    logic [3:0] th_d;
    logic [3:0] hu_d;
    logic [3:0] te_d;
    logic [3:0] on_d;
    logic       tone_out;
    logic       busy;
    logic       done;
    logic       err_bcd;

    int n_checks = 0;
    int n_fail   = 0;

    bcd_tone_generator #(
        .CLK_HZ          (1000),
        .DURATION_CYCLES (1000),
        .DIV_W           (11)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .stop           (stop),
        .Thousands_Data (th_d),
        .Hundreds_Data  (hu_d),
        .Tens_Data      (te_d),
        .Ones_Data      (on_d),
        .tone_out       (tone_out),
        .busy           (busy),
        .done           (done),
        .err_bcd        (err_bcd)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_digits(input logic [3:0] a, input logic [3:0] b,
                              input logic [3:0] c, input logic [3:0] d);
        th_d = a;
        hu_d = b;
        te_d = c;
        on_d = d;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_checks++;
        if (tone_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_tone: got %b expected 0", tone_out);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy: got %b expected 0", busy);
        end
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_done: got %b expected 0", done);
        end
        n_checks++;
        if (err_bcd !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_err: got %b expected 0", err_bcd);
        end
        reset = 1'b0;
        tick();
    endtask

    // Cycle 1 is the cycle after the edge that accepts start.
    task automatic test_tone(input string name,
                             input logic [3:0] a, input logic [3:0] b,
                             input logic [3:0] c, input logic [3:0] d,
                             input logic with_stop,
                             input int exp_edges, input int exp_first,
                             input int exp_done);
        int   cyc;
        int   edges;
        int   first;
        int   done_at;
        logic prev;
        set_digits(a, b, c, d);
        start = 1'b1;
        stop  = with_stop;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        set_digits(4'd9, 4'd9, 4'd9, 4'd9);
        cyc = 1;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_busy_start: got %b expected 1", name, busy);
        end
        n_checks++;
        if (err_bcd !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_err_start: got %b expected 0", name, err_bcd);
        end
        edges   = 0;
        first   = -1;
        done_at = -1;
        prev    = tone_out;
        while (done_at < 0 && cyc < 1300) begin
            tick();
            cyc++;
            if (tone_out && !prev) begin
                edges++;
                if (first < 0) first = cyc;
            end
            prev = tone_out;
            if (done) begin
                done_at = cyc;
                n_checks++;
                if (tone_out !== 1'b0 || busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s_done_outputs: got tone=%b busy=%b expected 0 0",
                             name, tone_out, busy);
                end
            end
        end
        n_checks++;
        if (edges != exp_edges) begin
            n_fail++;
            $display("FAIL %s_edges: got %0d expected %0d", name, edges, exp_edges);
        end
        n_checks++;
        if (first != exp_first) begin
            n_fail++;
            $display("FAIL %s_first_rise: got %0d expected %0d", name, first, exp_first);
        end
        n_checks++;
        if (done_at != exp_done) begin
            n_fail++;
            $display("FAIL %s_done_cycle: got %0d expected %0d", name, done_at, exp_done);
        end
        tick();
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || tone_out !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_after_done: got done=%b busy=%b tone=%b expected 0 0 0",
                     name, done, busy, tone_out);
        end
    endtask

    task automatic test_bcd_error();
        set_digits(4'd0, 4'hA, 4'd0, 4'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL err_cycle1: got busy=%b done=%b expected 1 0", busy, done);
        end
        tick();
        n_checks++;
        if (done !== 1'b1 || err_bcd !== 1'b1) begin
            n_fail++;
            $display("FAIL err_cycle2: got done=%b err=%b expected 1 1", done, err_bcd);
        end
        n_checks++;
        if (busy !== 1'b0 || tone_out !== 1'b0) begin
            n_fail++;
            $display("FAIL err_cycle2_idle: got busy=%b tone=%b expected 0 0",
                     busy, tone_out);
        end
        tick();
        n_checks++;
        if (done !== 1'b0 || err_bcd !== 1'b1) begin
            n_fail++;
            $display("FAIL err_sticky: got done=%b err=%b expected 0 1", done, err_bcd);
        end
        tick();
        // freq 1 -> half 500 -> a single rise at PLAY index 500 (cycle 517).
        test_tone("err_clear", 4'd0, 4'd0, 4'd0, 4'd1, 1'b0, 1, 517, 1017);
    endtask

    task automatic test_back_to_back_stop();
        int   cyc;
        int   edges;
        int   done_seen;
        logic prev;
        set_digits(4'd0, 4'd0, 4'd5, 4'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc       = 1;
        edges     = 0;
        done_seen = 0;
        prev      = tone_out;
        while (cyc < 317) begin
            tick();
            cyc++;
            if (tone_out && !prev) edges++;
            prev = tone_out;
            if (done) done_seen++;
            // A restart request with new digits mid-PLAY must be ignored.
            start = (cyc == 100);
            if (cyc == 100) set_digits(4'd0, 4'd1, 4'd2, 4'd3);
        end
        n_checks++;
        if (edges != 15) begin
            n_fail++;
            $display("FAIL stop_edges: got %0d expected 15", edges);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_checks++;
        if (tone_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_next: got tone=%b busy=%b done=%b expected 0 0 0",
                     tone_out, busy, done);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done) done_seen++;
        end
        n_checks++;
        if (done_seen != 0) begin
            n_fail++;
            $display("FAIL stop_no_done: got %0d expected 0", done_seen);
        end
    endtask

    task automatic test_reset_mid_run();
        set_digits(4'd0, 4'd0, 4'd5, 4'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 10; c++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if (tone_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err_bcd !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_divide: got tone=%b busy=%b done=%b err=%b expected 0 0 0 0",
                     tone_out, busy, done, err_bcd);
        end
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 32; c++) tick();
        n_checks++;
        if (tone_out !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_play_pre: got %b expected 1", tone_out);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if (tone_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err_bcd !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_play: got tone=%b busy=%b done=%b err=%b expected 0 0 0 0",
                     tone_out, busy, done, err_bcd);
        end
        tick();
        test_tone("after_reset", 4'd0, 4'd0, 4'd5, 4'd0, 1'b0, 50, 27, 1017);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        set_digits(4'd0, 4'd0, 4'd0, 4'd0);
        test_reset();
        // freq 50 -> half 10; first rise at PLAY index 10 (cycle 27).
        test_tone("f50", 4'd0, 4'd0, 4'd5, 4'd0, 1'b0, 50, 27, 1017);
        // freq 123 -> half 4; stop together with start in IDLE is ignored.
        test_tone("f123", 4'd0, 4'd1, 4'd2, 4'd3, 1'b1, 125, 21, 1017);
        // freq 0 -> divider skipped, PLAY from cycle 6, silent.
        test_tone("f0", 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 0, -1, 1006);
        // freq 600 -> quotient 0 clamped to half 1.
        test_tone("f600", 4'd0, 4'd6, 4'd0, 4'd0, 1'b0, 500, 18, 1017);
        test_bcd_error();
        test_back_to_back_stop();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
